data_capture_multi: RTL

- Single-clock, parametrised successor to the fast-capture/accumulate/transfer capture path.
- Continuously records samples into a per-event circular slot so that each event holds PRE_TRIG samples before the trigger.
- Collects NUM_EVENTS triggered events, then streams them out oldest-sample-first over a valid/ready interface, zero-extended to OUT_WIDTH.
- Sits between the ADC sample bus and the host transfer logic.

---
 rtl/data_capture_multi.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/data_capture_multi.sv
// data_capture_multi: multi-event pre/post-trigger sample capture with valid/ready readout.
module data_capture_multi #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH = 16,
  parameter int DEPTH = 128,
  parameter int PRE_TRIG = 16,
  parameter int NUM_EVENTS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arm,
  input  logic abort,
  input  logic sample_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic trig,
  output logic [OUT_WIDTH-1:0] dout,
  output logic dout_valid,
  input  logic dout_ready,
  output logic dout_last,
  output logic busy,
  output logic [$clog2(NUM_EVENTS+1)-1:0] events_captured,
  output logic data_ready_to_read
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = NUM_EVENTS > 1 ? $clog2(NUM_EVENTS) : 1;
  localparam int MW = $clog2(NUM_EVENTS*DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] PRE_LAST = CW'(PRE_TRIG - 1);
  localparam logic [CW-1:0] POST_LAST = CW'(DEPTH - PRE_TRIG - 1);
  localparam logic [EW-1:0] EV_LAST = EW'(NUM_EVENTS - 1);
  localparam logic [AW-1:0] PT = AW'(PRE_TRIG);
  localparam logic [AW-1:0] WLAST = AW'(DEPTH - 1);
  typedef enum logic [2:0] {IDLE, PREFILL, WAIT_TRIG, POST, NEXT, READOUT} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] mem [NUM_EVENTS*DEPTH];
  logic [DATA_WIDTH-1:0] rdata;
  logic [AW-1:0] wp, rcnt;
  logic [AW-1:0] start [NUM_EVENTS];
  logic [CW-1:0] cnt, post;
  logic [EW-1:0] ev, rev;
  logic trig_q, rdone, rise, we, re;
  logic [MW-1:0] waddr, raddr;
  always_comb begin
    rise = trig & ~trig_q;
    we = sample_en && (state == PREFILL || state == WAIT_TRIG || state == POST);
    re = state == READOUT && !abort && !rdone && (!dout_valid || dout_ready);
    waddr = MW'(ev) * MW'(DEPTH) + MW'(wp);
    raddr = MW'(rev) * MW'(DEPTH) + MW'(AW'(start[rev] + rcnt));
  end
  assign dout = dout_valid ? OUT_WIDTH'(rdata) : '0;
  assign busy = state != IDLE;
  assign data_ready_to_read = state == READOUT;
  // rdata doubles as the output register; it only advances when the consumer can take a word
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
    if (re) rdata <= mem[raddr];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      trig_q <= 1'b0;
      wp <= '0;
      rcnt <= '0;
      cnt <= '0;
      post <= '0;
      ev <= '0;
      rev <= '0;
      rdone <= 1'b0;
      dout_valid <= 1'b0;
      dout_last <= 1'b0;
      events_captured <= '0;
      for (int i = 0; i < NUM_EVENTS; i++) start[i] <= '0;
    end else begin
      trig_q <= trig;
      if (abort) begin
        state <= IDLE;
        wp <= '0;
        rcnt <= '0;
        cnt <= '0;
        post <= '0;
        ev <= '0;
        rev <= '0;
        rdone <= 1'b0;
        dout_valid <= 1'b0;
        dout_last <= 1'b0;
        events_captured <= '0;
      end else begin
        case (state)
          IDLE: if (arm) begin
            state <= PRE_TRIG == 0 ? WAIT_TRIG : PREFILL;
            ev <= '0;
            wp <= '0;
            cnt <= '0;
          end
          PREFILL: if (sample_en) begin
            wp <= wp + 1'b1;
            cnt <= cnt + 1'b1;
            if (cnt == PRE_LAST) state <= WAIT_TRIG;
          end
          WAIT_TRIG: if (sample_en) begin
            wp <= wp + 1'b1;
            if (rise) begin
              start[ev] <= wp - PT;
              post <= CW'(1);
              state <= POST_LAST == '0 ? NEXT : POST;
            end
          end
          POST: if (sample_en) begin
            wp <= wp + 1'b1;
            post <= post + 1'b1;
            if (post == POST_LAST) state <= NEXT;
          end
          NEXT: begin
            ev <= ev == EV_LAST ? '0 : ev + 1'b1;
            wp <= '0;
            cnt <= '0;
            events_captured <= events_captured + 1'b1;
            if (ev == EV_LAST) begin
              state <= READOUT;
              rev <= '0;
              rcnt <= '0;
              rdone <= 1'b0;
            end else state <= PRE_TRIG == 0 ? WAIT_TRIG : PREFILL;
          end
          READOUT: if (dout_valid && dout_ready && rdone) begin
            state <= IDLE;
            dout_valid <= 1'b0;
            dout_last <= 1'b0;
            rdone <= 1'b0;
            events_captured <= '0;
          end else if (re) begin
            dout_valid <= 1'b1;
            dout_last <= rcnt == WLAST;
            rcnt <= rcnt + 1'b1;
            if (rcnt == WLAST) begin
              if (rev == EV_LAST) rdone <= 1'b1;
              else rev <= rev + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
